rf_wb_arbiter: RTL and testbench

- Shares the two write ports (we1/waddr1/wdata1, we2/waddr2/wdata2) of the 4-read/2-write register-file RAM among NUM_REQ writeback requesters (ALU0, ALU1, MUL, LSU).
- Sits between the functional-unit writeback buses and the register-file RAM.
- Grants up to two requests per cycle using a round-robin scheme.
- Never issues two same-cycle writes to one address, and never writes physical register 0 when ZERO_DROP=1.

---
 rtl/rf_wb_arbiter_if.sv | 26 ++
 rtl/rf_wb_arbiter.sv | 136 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus between the functional units and the register-file arbiter.
// Requester i occupies lane i of each packed vector.
interface rf_wb_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the two register-file write ports among NUM_REQ writeback units.
// Grants at most two requests per cycle with distinct addresses; write ports are registered.
module rf_wb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DATA_W    = 32,
  parameter bit          ZERO_DROP = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       stall_i,
  rf_wb_arbiter_if.slave             req_if,
  output logic                       we1_o,
  output logic [ADDR_W-1:0]          waddr1_o,
  output logic [DATA_W-1:0]          wdata1_o,
  output logic                       we2_o,
  output logic [ADDR_W-1:0]          waddr2_o,
  output logic [DATA_W-1:0]          wdata2_o,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr_o
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned SumW = PtrW + 1;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_if.req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_if.req_data[i*DATA_W +: DATA_W];
  end

  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              we1_q, we1_d, we2_q, we2_d;
  logic [ADDR_W-1:0] waddr1_q, waddr1_d, waddr2_q, waddr2_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;

  logic              arb_en;
  logic              g1_vld, g2_vld;
  logic [PtrW-1:0]   g1_idx, g2_idx, last_idx;
  logic [NUM_REQ-1:0] ready;

  // Ready is forced low during reset so nothing is handshaken while state is cleared.
  assign arb_en = rst_ni & ~stall_i;

  // Circular scan from rr_ptr: first valid is G1, next valid with a different address is G2.
  always_comb begin
    logic [SumW-1:0] sum;
    logic [PtrW-1:0] idx;
    sum    = '0;
    idx    = '0;
    g1_vld = 1'b0;
    g1_idx = '0;
    g2_vld = 1'b0;
    g2_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (sum >= SumW'(NUM_REQ)) begin
        sum = sum - SumW'(NUM_REQ);
      end
      idx = sum[PtrW-1:0];
      if (arb_en && req_if.req_valid[idx]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = idx;
        end else if (!g2_vld && (addr_arr[idx] != addr_arr[g1_idx])) begin
          g2_vld = 1'b1;
          g2_idx = idx;
        end
      end
    end
  end

  always_comb begin
    ready    = '0;
    rr_ptr_d = rr_ptr_q;
    last_idx = g1_idx;
    we1_d    = 1'b0;
    waddr1_d = waddr1_q;
    wdata1_d = wdata1_q;
    we2_d    = 1'b0;
    waddr2_d = waddr2_q;
    wdata2_d = wdata2_q;

    if (g1_vld) begin
      ready[g1_idx] = 1'b1;
      // Address-0 writes still consume the slot, they just never reach the RAM.
      we1_d    = !(ZERO_DROP && (addr_arr[g1_idx] == '0));
      waddr1_d = addr_arr[g1_idx];
      wdata1_d = data_arr[g1_idx];
    end

    if (g2_vld) begin
      ready[g2_idx] = 1'b1;
      we2_d    = !(ZERO_DROP && (addr_arr[g2_idx] == '0));
      waddr2_d = addr_arr[g2_idx];
      wdata2_d = data_arr[g2_idx];
      last_idx = g2_idx;
    end

    if (g1_vld) begin
      rr_ptr_d = (last_idx == PtrW'(NUM_REQ - 1)) ? '0 : last_idx + PtrW'(1);
    end
  end

  assign req_if.req_ready = ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      we1_q    <= 1'b0;
      waddr1_q <= '0;
      wdata1_q <= '0;
      we2_q    <= 1'b0;
      waddr2_q <= '0;
      wdata2_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we1_q    <= we1_d;
      waddr1_q <= waddr1_d;
      wdata1_q <= wdata1_d;
      we2_q    <= we2_d;
      waddr2_q <= waddr2_d;
      wdata2_q <= wdata2_d;
    end
  end

  assign we1_o    = we1_q;
  assign waddr1_o = waddr1_q;
  assign wdata1_o = wdata1_q;
  assign we2_o    = we2_q;
  assign waddr2_o = waddr2_q;
  assign wdata2_o = wdata2_q;
  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by random traffic
// compared against a list-based grant model and a shadow register file.
module tb_rf_wb_arbiter;
  localparam int unsigned NUM = 4;
  localparam int unsigned AW  = 6;
  localparam int unsigned DW  = 32;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          stall_i = 1'b0;
  logic          we1, we2;
  logic [AW-1:0] wa1, wa2;
  logic [DW-1:0] wd1, wd2;
  logic [1:0]    rr_ptr;

  rf_wb_arbiter_if #(.NUM_REQ(NUM), .ADDR_W(AW), .DATA_W(DW)) req_if ();

  rf_wb_arbiter #(
    .NUM_REQ  (NUM),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .ZERO_DROP(1'b1)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (stall_i),
    .req_if  (req_if),
    .we1_o   (we1),
    .waddr1_o(wa1),
    .wdata1_o(wd1),
    .we2_o   (we2),
    .waddr2_o(wa2),
    .wdata2_o(wd2),
    .rr_ptr_o(rr_ptr)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Requester state and reference model
  bit            v [NUM];
  logic [AW-1:0] a [NUM];
  logic [DW-1:0] d [NUM];
  int            m_ptr;
  logic [DW-1:0] m_ram [64];
  logic [DW-1:0] ram [64];
  logic [AW-1:0] pa_q[$];
  logic [DW-1:0] pd_q[$];
  int            wait_cnt [NUM];
  int            max_wait;
  logic [NUM-1:0] last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NUM); i++) begin
      req_if.req_valid[i]           = v[i];
      req_if.req_addr[i*AW +: AW]   = a[i];
      req_if.req_data[i*DW +: DW]   = d[i];
    end
  endtask

  // Shadow RAM: DUT outputs are stable mid-cycle and get stored at the coming edge.
  task automatic ram_capture();
    if (we1) ram[wa1] = wd1;
    if (we2) ram[wa2] = wd2;
  endtask

  task automatic model_grant(input bit stall, output logic [NUM-1:0] rdy,
                             output int g1, output int g2);
    int order[$];
    rdy = '0;
    g1  = -1;
    g2  = -1;
    if (!stall) begin
      for (int k = 0; k < int'(NUM); k++) begin
        int i;
        i = (m_ptr + k) % int'(NUM);
        if (v[i]) order.push_back(i);
      end
      if (order.size() > 0) begin
        g1 = order[0];
        for (int j = 1; j < order.size(); j++) begin
          if (g2 < 0 && a[order[j]] != a[g1]) g2 = order[j];
        end
      end
      if (g1 >= 0) rdy[g1] = 1'b1;
      if (g2 >= 0) rdy[g2] = 1'b1;
    end
  endtask

  task automatic step(input bit stall);
    logic [NUM-1:0] er;
    int g1, g2;
    bit e1, e2;
    stall_i = stall;
    drive();
    #1;
    model_grant(stall, er, g1, g2);
    last_ready = req_if.req_ready;
    check("ready", 64'(req_if.req_ready), 64'(er));
    for (int i = 0; i < int'(NUM); i++) begin
      if (v[i] && !last_ready[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    ram_capture();
    @(posedge clk_i);
    #1;
    foreach (pa_q[j]) m_ram[pa_q[j]] = pd_q[j];
    pa_q.delete();
    pd_q.delete();
    e1 = 1'b0;
    e2 = 1'b0;
    if (g1 >= 0) e1 = (a[g1] != '0);
    if (g2 >= 0) e2 = (a[g2] != '0);
    check("we1", 64'(we1), 64'(e1));
    check("we2", 64'(we2), 64'(e2));
    if (e1) begin
      check("waddr1", 64'(wa1), 64'(a[g1]));
      check("wdata1", 64'(wd1), 64'(d[g1]));
      pa_q.push_back(a[g1]);
      pd_q.push_back(d[g1]);
    end
    if (e2) begin
      check("waddr2", 64'(wa2), 64'(a[g2]));
      check("wdata2", 64'(wd2), 64'(d[g2]));
      pa_q.push_back(a[g2]);
      pd_q.push_back(d[g2]);
    end
    if (we1 && we2) check("port_addr_distinct", 64'(wa1 != wa2), 64'(1));
    if (g2 >= 0) m_ptr = (g2 + 1) % int'(NUM);
    else if (g1 >= 0) m_ptr = (g1 + 1) % int'(NUM);
    check("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
    if (g1 >= 0) v[g1] = 1'b0;
    if (g2 >= 0) v[g2] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] ad, input logic [DW-1:0] da);
    v[i] = 1'b1;
    a[i] = ad;
    d[i] = da;
  endtask

  initial begin
    logic [NUM-1:0] er;
    int g1, g2;
    m_ptr    = 0;
    max_wait = 0;
    for (int i = 0; i < 64; i++) begin
      m_ram[i] = '0;
      ram[i]   = '0;
    end
    for (int i = 0; i < int'(NUM); i++) begin
      v[i] = 1'b0;
      a[i] = '0;
      d[i] = '0;
      wait_cnt[i] = 0;
    end
    // Reset state, with requests present to show ready is held low
    for (int i = 0; i < int'(NUM); i++) set_req(i, AW'(i + 1), DW'(i));
    drive();
    #3;
    check("rst_ready", 64'(req_if.req_ready), 64'(0));
    check("rst_we1", 64'(we1), 64'(0));
    check("rst_we2", 64'(we2), 64'(0));
    check("rst_ptr", 64'(rr_ptr), 64'(0));
    for (int i = 0; i < int'(NUM); i++) v[i] = 1'b0;
    drive();
    #9 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Two distinct requesters
    set_req(0, 6'd5, 32'hAAAA);
    set_req(1, 6'd9, 32'hBBBB);
    step(1'b0);
    check("two_ready", 64'(last_ready), 64'(4'b0011));
    check("two_ptr", 64'(rr_ptr), 64'(2));

    set_req(2, 6'd20, 32'h2020);
    set_req(3, 6'd21, 32'h2121);
    step(1'b0);

    // Same-address conflict
    set_req(0, 6'd7, 32'h1111);
    set_req(1, 6'd7, 32'h2222);
    step(1'b0);
    check("conf_ready0", 64'(last_ready), 64'(4'b0001));
    step(1'b0);
    check("conf_ready1", 64'(last_ready), 64'(4'b0010));
    step(1'b0);
    check("conf_ram7", 64'(ram[7]), 64'(32'h2222));

    set_req(2, 6'd22, 32'h2222_0000);
    set_req(3, 6'd23, 32'h2323_0000);
    step(1'b0);

    // Fairness and wrap: all four stay valid
    max_wait = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(NUM); i++) if (!v[i]) set_req(i, AW'(10 + i), DW'(32'hF000 + r * 16 + i));
      step(1'b0);
      check("fair_ready", 64'(last_ready), (r == 1) ? 64'(4'b1100) : 64'(4'b0011));
      check("fair_ptr", 64'(rr_ptr), (r == 1) ? 64'(0) : 64'(2));
    end
    check("fair_wait", 64'(max_wait <= 2), 64'(1));
    for (int i = 0; i < int'(NUM); i++) v[i] = 1'b0;

    // Zero drop
    set_req(2, 6'd0, 32'hDEAD);
    step(1'b0);
    check("zero_ready", 64'(last_ready), 64'(4'b0100));
    check("zero_we1", 64'(we1), 64'(0));

    // Stall
    for (int i = 0; i < int'(NUM); i++) set_req(i, AW'(40 + i), DW'(32'h5000 + i));
    step(1'b1);
    check("stall_ready", 64'(last_ready), 64'(0));
    check("stall_ptr", 64'(rr_ptr), 64'(3));

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NUM); i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) set_req(i, AW'($urandom_range(0, 7)), $urandom);
      end
      step($urandom_range(0, 7) == 0);
    end
    for (int c = 0; c < 10; c++) step(1'b0);

    // Async reset right after a grant edge
    set_req(0, 6'd30, 32'h3030);
    set_req(1, 6'd31, 32'h3131);
    stall_i = 1'b0;
    drive();
    #1;
    model_grant(1'b0, er, g1, g2);
    check("rstmid_ready", 64'(req_if.req_ready), 64'(er));
    ram_capture();
    @(posedge clk_i);
    foreach (pa_q[j]) m_ram[pa_q[j]] = pd_q[j];
    pa_q.delete();
    pd_q.delete();
    #1;
    check("rstmid_we1_pre", 64'(we1), 64'(1));
    #1 rst_ni = 1'b0;
    #1;
    check("rstmid_we1", 64'(we1), 64'(0));
    check("rstmid_we2", 64'(we2), 64'(0));
    check("rstmid_ready0", 64'(req_if.req_ready), 64'(0));
    check("rstmid_ptr", 64'(rr_ptr), 64'(0));
    v[0] = 1'b0;
    v[1] = 1'b0;
    m_ptr = 0;
    drive();
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step(1'b0);
    step(1'b0);

    for (int i = 0; i < 64; i++) check($sformatf("ram[%0d]", i), 64'(ram[i]), 64'(m_ram[i]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
